dot_product_mac: RTL and testbench

Consumer stage behind the two operand memories (vector A, vector B) of the dot-product datapath. On a start pulse it streams reads from both memories in lockstep, multiplies element pairs and accumulates them. It then presents the scalar result with a valid/ready handshake. It drives the memories' read_en/read_address and absorbs their 1-cycle registered read latency.

---
 rtl/dot_product_mac.sv | 105 ++++++++++
 tb/tb_dot_product_mac.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/dot_product_mac.sv
// rtl/dot_product_mac.sv - streams paired reads from operand memories A/B and accumulates their dot product
// Define SIGNED_MAC_EN for two's-complement operands and a signed result; default build is unsigned.
module dot_product_mac #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH+ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   vec_len,
    output logic                  busy,
    output logic                  a_read_en,
    output logic [ADDR_WIDTH-1:0] a_read_address,
    input  logic [DATA_WIDTH-1:0] a_data_in,
    output logic                  b_read_en,
    output logic [ADDR_WIDTH-1:0] b_read_address,
    input  logic [DATA_WIDTH-1:0] b_data_in,
    output logic [ACC_WIDTH-1:0]  result,
    output logic                  result_valid,
    input  logic                  result_ready
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    localparam logic [ADDR_WIDTH:0]   LEN_ONE  = 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

    state_t                  state, state_d;
    logic [ADDR_WIDTH:0]     len;
    logic [ADDR_WIDTH-1:0]   addr;
    logic                    read_en;
    logic                    rd_vld;
    logic                    last_read;
    logic                    accept;
    logic [2*DATA_WIDTH-1:0] prod;
    logic [ACC_WIDTH-1:0]    acc, acc_next;

    assign accept    = (state == IDLE) && start;
    assign last_read = ({1'b0, addr} == (len - LEN_ONE));

`ifdef SIGNED_MAC_EN
    assign prod     = (2*DATA_WIDTH)'($signed(a_data_in)) * (2*DATA_WIDTH)'($signed(b_data_in));
    assign acc_next = acc + ACC_WIDTH'($signed(prod));
`else
    assign prod     = (2*DATA_WIDTH)'(a_data_in) * (2*DATA_WIDTH)'(b_data_in);
    assign acc_next = acc + ACC_WIDTH'(prod);
`endif

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (start) state_d = (vec_len == '0) ? DONE : READ;
            READ:    if (last_read) state_d = DRAIN;
            DRAIN:   state_d = DONE;
            DONE:    if (result_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            len          <= '0;
            addr         <= '0;
            read_en      <= 1'b0;
            rd_vld       <= 1'b0;
            acc          <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_d;
            busy         <= (state_d != IDLE);
            read_en      <= (state_d == READ);
            result_valid <= (state_d == DONE);
            rd_vld       <= read_en;

            if (accept) begin
                len  <= vec_len;
                addr <= '0;
            end else if (state == READ && !last_read) begin
                addr <= addr + ADDR_ONE;
            end

            if (accept)
                acc <= '0;
            else if (rd_vld)
                acc <= acc_next;

            // DRAIN is the cycle the final product arrives, so fold it in directly.
            if (accept && vec_len == '0)
                result <= '0;
            else if (state == DRAIN)
                result <= rd_vld ? acc_next : acc;
        end
    end

    assign a_read_en      = read_en;
    assign b_read_en      = read_en;
    assign a_read_address = addr;
    assign b_read_address = addr;

endmodule

// File: tb/tb_dot_product_mac.sv
// tb/tb_dot_product_mac.sv - self-checking bench for dot_product_mac
module tb_dot_product_mac;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int ACC_W = 2*DW+AW;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [AW:0]      vec_len;
    logic             busy;
    logic             a_read_en, b_read_en;
    logic [AW-1:0]    a_read_address, b_read_address;
    logic [DW-1:0]    a_data_in, b_data_in;
    logic [ACC_W-1:0] result;
    logic             result_valid;
    logic             result_ready;

    logic [DW-1:0] mem_a [16];
    logic [DW-1:0] mem_b [16];

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        int               len;
        logic [127:0]     a;
        logic [127:0]     b;
        logic [ACC_W-1:0] exp;
        int               lat;
        bit               extra;
        string            name;
    } vec_t;

    vec_t tbl [5];

    dot_product_mac #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .vec_len        (vec_len),
        .busy           (busy),
        .a_read_en      (a_read_en),
        .a_read_address (a_read_address),
        .a_data_in      (a_data_in),
        .b_read_en      (b_read_en),
        .b_read_address (b_read_address),
        .b_data_in      (b_data_in),
        .result         (result),
        .result_valid   (result_valid),
        .result_ready   (result_ready)
    );

    always #5 clk = ~clk;

    // Operand memories with one cycle of registered read latency.
    always @(posedge clk) begin
        if (a_read_en) a_data_in <= mem_a[a_read_address];
        if (b_read_en) b_data_in <= mem_b[b_read_address];
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic logic [ACC_W-1:0] model(input int n);
        longint s = 0;
        for (int i = 0; i < n; i++) begin
`ifdef SIGNED_MAC_EN
            s += longint'($signed(mem_a[i])) * longint'($signed(mem_b[i]));
`else
            s += longint'(mem_a[i]) * longint'(mem_b[i]);
`endif
        end
        return ACC_W'(s);
    endfunction

    task automatic run_job(input int n, input int ready_lat, input bit extra,
                           input logic [ACC_W-1:0] exp, input string tag);
        int cyc = 0, nreads = 0, waited = 0, valid_cyc = -1;
        bit seen = 0, hs = 0, done = 0, busy_ok = 1, addr_ok = 1, stable_ok = 1, idle_ok = 1;
        logic [ACC_W-1:0] res = '0;
        @(negedge clk);
        start        = 1'b1;
        vec_len      = (AW+1)'(n);
        result_ready = (ready_lat == 0);
        @(posedge clk);
        #1;
        start   = 1'b0;
        vec_len = (AW+1)'($urandom);
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (hs) begin
                done = 1;
                check({tag, " valid_after_hs"}, result_valid, 0);
                check({tag, " busy_after_hs"}, busy, 0);
            end else begin
                if (!busy) busy_ok = 0;
                if (a_read_en) begin
                    if (a_read_address != nreads[AW-1:0] || !b_read_en ||
                        b_read_address != a_read_address) addr_ok = 0;
                    nreads++;
                end else if (b_read_en) begin
                    addr_ok = 0;
                end
                if (result_valid) begin
                    if (!seen) begin
                        seen = 1; valid_cyc = cyc; res = result;
                    end else if (result !== res) begin
                        stable_ok = 0;
                    end
                    if (waited >= ready_lat) begin
                        result_ready = 1'b1; hs = 1;
                    end else begin
                        waited++; result_ready = 1'b0;
                        if (extra) start = 1'b1;
                    end
                end
            end
        end
        result_ready = 1'b0;
        check({tag, " completed"}, done, 1);
        check({tag, " result"}, res, exp);
        check({tag, " valid_cycle"}, valid_cyc, (n == 0) ? 1 : n + 2);
        check({tag, " read_count"}, nreads, n);
        check({tag, " addr_seq"}, addr_ok, 1);
        check({tag, " busy_held"}, busy_ok, 1);
        if (ready_lat > 0) check({tag, " result_stable"}, stable_ok, 1);
        if (extra) begin
            repeat (4) begin
                @(negedge clk);
                if (busy || result_valid || a_read_en) idle_ok = 0;
            end
            check({tag, " no_extra_job"}, idle_ok, 1);
        end
    endtask

    initial begin
        logic [ACC_W-1:0] e_mix;
        int n, lat, guard;
        rst = 1'b1; start = 1'b0; vec_len = '0; result_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy", busy, 0);
        check("reset a_read_en", a_read_en, 0);
        check("reset b_read_en", b_read_en, 0);
        check("reset a_addr", a_read_address, 0);
        check("reset b_addr", b_read_address, 0);
        check("reset result", result, 0);
        check("reset valid", result_valid, 0);
        rst = 1'b0;

`ifdef SIGNED_MAC_EN
        e_mix = 20'hFFFF5;
`else
        e_mix = 20'd1269;
`endif
        tbl[0] = '{4, 128'({8'd4, 8'd3, 8'd2, 8'd1}), 128'({8'd8, 8'd7, 8'd6, 8'd5}), 20'd70, 0, 0, "len4"};
        tbl[1] = '{16, {16{8'hFF}}, {16{8'hFF}}, 20'hFE010, 0, 0, "len16_ff"};
        tbl[2] = '{0, 128'(0), 128'(0), 20'd0, 0, 0, "len0"};
        tbl[3] = '{2, 128'({8'd1, 8'd1}), 128'({8'd2, 8'd2}), 20'd4, 5, 1, "backpressure"};
        tbl[4] = '{2, 128'({8'h02, 8'hFF}), 128'({8'hFC, 8'h03}), e_mix, 1, 0, "mixed_sign"};

        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 16; i++) begin
                mem_a[i] = tbl[k].a[i*8 +: 8];
                mem_b[i] = tbl[k].b[i*8 +: 8];
            end
            run_job(tbl[k].len, tbl[k].lat, tbl[k].extra, tbl[k].exp, tbl[k].name);
        end

        // Abort a run mid-stream, then confirm the next run starts clean.
        for (int i = 0; i < 16; i++) begin
            mem_a[i] = DW'($urandom); mem_b[i] = DW'($urandom);
        end
        @(negedge clk);
        start = 1'b1; vec_len = 5'd8;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (!(a_read_en && a_read_address == 4'd2) && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("midreset reached index2", guard < 20, 1);
        rst = 1'b1;
        @(negedge clk);
        check("midreset busy", busy, 0);
        check("midreset read_en", a_read_en | b_read_en, 0);
        check("midreset addr", {a_read_address, b_read_address}, 0);
        check("midreset result", result, 0);
        check("midreset valid", result_valid, 0);
        rst = 1'b0;
        mem_a[0] = 8'd3; mem_a[1] = 8'd3; mem_b[0] = 8'd4; mem_b[1] = 8'd4;
        run_job(2, 0, 0, 20'd24, "after_reset");

        for (int r = 0; r < 20; r++) begin
            n   = $urandom_range(0, 16);
            lat = $urandom_range(0, 3);
            for (int i = 0; i < 16; i++) begin
                mem_a[i] = DW'($urandom); mem_b[i] = DW'($urandom);
            end
            run_job(n, lat, 1'b0, model(n), $sformatf("rand%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
